encoder_4_2_df: RTL and testbench



---
 rtl/encoder_pkg.sv | 19 +
 rtl/enc4_2_prio.sv | 26 ++
 rtl/encoder_4_2_df.sv | 38 +++
 tb/tb_encoder_4_2_df.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared widths, index codes and reset value for the 4-to-2 encoder
package encoder_pkg;

  localparam int ENC_IN_W  = 4;
  localparam int ENC_OUT_W = 2;

  localparam logic [ENC_OUT_W-1:0] IDX0 = 2'b00;
  localparam logic [ENC_OUT_W-1:0] IDX1 = 2'b01;
  localparam logic [ENC_OUT_W-1:0] IDX2 = 2'b10;
  localparam logic [ENC_OUT_W-1:0] IDX3 = 2'b11;

  localparam logic [ENC_OUT_W-1:0] Y_RST = 2'b00;

  // True when at least two request bits are set: clearing the lowest set bit leaves something.
  function automatic logic more_than_one(input logic [ENC_IN_W-1:0] req);
    return (req & (req - ENC_IN_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/enc4_2_prio.sv
// rtl/enc4_2_prio.sv - combinational priority encode, bit 3 highest, gated by enable
import encoder_pkg::*;

module enc4_2_prio (
  input  logic [ENC_IN_W-1:0]  I,
  input  logic                 e,
  output logic [ENC_OUT_W-1:0] y_nxt,
  output logic                 valid_nxt,
  output logic                 multi_nxt
);

  always_comb begin
    y_nxt     = Y_RST;
    valid_nxt = 1'b0;
    multi_nxt = 1'b0;
    if (e) begin
      if (I[3])      y_nxt = IDX3;
      else if (I[2]) y_nxt = IDX2;
      else if (I[1]) y_nxt = IDX1;
      else           y_nxt = IDX0;
      valid_nxt = (I != '0);
      multi_nxt = more_than_one(I);
    end
  end

endmodule

// File: rtl/encoder_4_2_df.sv
// rtl/encoder_4_2_df.sv - registered 4-to-2 priority encoder with valid/multi flags
import encoder_pkg::*;

module encoder_4_2_df (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ENC_IN_W-1:0]  I,
  input  logic                 e,
  output logic [ENC_OUT_W-1:0] y,
  output logic                 valid,
  output logic                 multi
);

  logic [ENC_OUT_W-1:0] y_nxt;
  logic                 valid_nxt;
  logic                 multi_nxt;

  enc4_2_prio u_prio (
    .I         (I),
    .e         (e),
    .y_nxt     (y_nxt),
    .valid_nxt (valid_nxt),
    .multi_nxt (multi_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= Y_RST;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      y     <= y_nxt;
      valid <= valid_nxt;
      multi <= multi_nxt;
    end
  end

endmodule

// File: tb/tb_encoder_4_2_df.sv
// tb/tb_encoder_4_2_df.sv - scoreboard bench: directed plan plus random stimulus vs reference model
module tb_encoder_4_2_df;

  typedef struct {
    logic [1:0] y;
    logic       v;
    logic       m;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] I = 4'b0000;
  logic       e = 1'b0;
  logic [1:0] y;
  logic       valid;
  logic       multi;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  encoder_4_2_df dut (
    .clk   (clk),
    .rst_n (rst_n),
    .I     (I),
    .e     (e),
    .y     (y),
    .valid (valid),
    .multi (multi)
  );

  always #5 clk = ~clk;

  // Highest set bit index, plus flags from a plain bit count.
  function automatic exp_t model(input logic [3:0] i, input logic en, input string tag);
    exp_t r;
    r.y = 2'b00; r.v = 1'b0; r.m = 1'b0; r.tag = tag;
    if (en && i != 4'b0000) begin
      for (int b = 0; b < 4; b++) if (i[b]) r.y = 2'(b);
      r.v = 1'b1;
      r.m = ($countones(i) >= 2);
    end
    return r;
  endfunction

  task automatic check(input exp_t x);
    checks++;
    if (y !== x.y || valid !== x.v || multi !== x.m) begin
      errors++;
      $display("FAIL %s: got y=%b valid=%b multi=%b, required y=%b valid=%b multi=%b",
               x.tag, y, valid, multi, x.y, x.v, x.m);
    end
  endtask

  task automatic apply(input logic [3:0] i, input logic en, input string tag);
    @(negedge clk);
    I = i;
    e = en;
    sb.push_back(model(i, en, tag));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: the DUT presents a result every cycle; compare whatever was issued.
  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) check(sb.pop_front());
  end

  exp_t cleared;

  initial begin
    cleared = model(4'b0000, 1'b0, "reset_hold");

    I = 4'b1111;
    e = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 check(cleared);

    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model(I, e, "reset_release"));
    drain();

    apply(4'b1000, 1'b1, "onehot_1000");
    apply(4'b0100, 1'b1, "onehot_0100");
    apply(4'b0010, 1'b1, "onehot_0010");
    apply(4'b0001, 1'b1, "onehot_0001");

    apply(4'b0100, 1'b0, "enable_off");
    apply(4'b0100, 1'b1, "enable_on");

    apply(4'b0110, 1'b1, "multi_0110");
    apply(4'b1001, 1'b1, "multi_1001");
    apply(4'b0011, 1'b1, "multi_0011");

    apply(4'b0000, 1'b1, "zero_input");
    apply(4'b0001, 1'b1, "zero_contrast");
    apply(4'b1111, 1'b0, "disabled_all");

    for (int k = 0; k < 200; k++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      apply(r, ($urandom_range(0, 7) != 0), "random");
    end
    drain();

    // Async clear between edges, held through an edge, released mid-cycle.
    apply(4'b1000, 1'b1, "pre_reset_y11");
    drain();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 begin cleared.tag = "async_clear_immediate"; check(cleared); end
    @(posedge clk);
    #1 begin cleared.tag = "async_clear_held"; check(cleared); end
    @(negedge clk);
    rst_n = 1'b1;
    #1 begin cleared.tag = "async_clear_after_release"; check(cleared); end
    sb.push_back(model(I, e, "first_edge_after_release"));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
